// File: rtl/kbd_pkg.sv
// Shared types and helpers for the key matrix scanner.
//   kbd_state_t : debounce FSM states
//   frame_cls_t : classification of one completed scan frame
//   code_w()    : bit width needed to index n items (minimum 1)
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    PRESSED,
    REL
  } kbd_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_cls_t;

  function automatic int unsigned code_w(input int unsigned n_items);
    return (n_items > 1) ? $clog2(n_items) : 1;
  endfunction

endpackage

// File: rtl/kbd_col_scan.sv
// Column driver, row synchronizer and per-frame key accumulator.
// Ports:
//   clk, RST        : clock, synchronous active-high reset
//   i_row_n         : raw active-low row lines (asynchronous)
//   o_col_n         : column drive, one bit low
//   o_frame_done    : one-cycle pulse after the last column of a frame is sampled
//   o_frame_cls     : NONE / SINGLE / MULTI for the completed frame
//   o_frame_code    : code of the first key found in the completed frame
module kbd_col_scan
  import kbd_pkg::*;
#(
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic [ROWS-1:0]                 i_row_n,
  output logic [COLS-1:0]                 o_col_n,
  output logic                            o_frame_done,
  output frame_cls_t                      o_frame_cls,
  output logic [code_w(ROWS*COLS)-1:0]    o_frame_code
);

  localparam int unsigned SLOT_W = code_w(SCAN_DIV);
  localparam int unsigned COL_W  = code_w(COLS);
  localparam int unsigned ROW_W  = code_w(ROWS);
  localparam int unsigned CODE_W = code_w(ROWS * COLS);

  logic [SLOT_W-1:0] r_slot;
  logic [COL_W-1:0]  r_col;
  logic [COLS-1:0]   r_col_n;
  logic [ROWS-1:0]   r_sync1;
  logic [ROWS-1:0]   r_sync2;
  logic [1:0]        r_acc_cnt;
  logic [CODE_W-1:0] r_acc_code;
  logic              r_frame_done;
  frame_cls_t        r_frame_cls;
  logic [CODE_W-1:0] r_frame_code;

  logic              w_slot_end;
  logic              w_col_last;
  logic [COL_W-1:0]  w_col_next;
  logic [1:0]        w_col_hits;
  logic [ROW_W-1:0]  w_col_row;
  logic [CODE_W-1:0] w_col_code;
  logic [2:0]        w_sum;
  logic [1:0]        w_acc_cnt;
  logic [CODE_W-1:0] w_acc_code;

  // Count keys down in the sampled column (saturating at 2) and find the lowest row.
  always_comb begin
    w_slot_end = (r_slot == SLOT_W'(SCAN_DIV - 1));
    w_col_last = (r_col == COL_W'(COLS - 1));
    w_col_next = w_col_last ? '0 : r_col + COL_W'(1);
    w_col_hits = 2'd0;
    w_col_row  = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!r_sync2[r]) w_col_row = ROW_W'(r);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (!r_sync2[r] && (w_col_hits != 2'd2)) w_col_hits = w_col_hits + 2'd1;
    end
    w_col_code = CODE_W'(w_col_row) * CODE_W'(COLS) + CODE_W'(r_col);
    w_sum      = {1'b0, r_acc_cnt} + {1'b0, w_col_hits};
    w_acc_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    // Scan order is column-major, so the first hit of the frame wins.
    w_acc_code = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;
  end

  // Slot counter, column advance, synchronizer and frame accumulator.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_slot       <= '0;
      r_col        <= '0;
      r_col_n      <= ~(COLS'(1));
      r_sync1      <= '1;
      r_sync2      <= '1;
      r_acc_cnt    <= 2'd0;
      r_acc_code   <= '0;
      r_frame_done <= 1'b0;
      r_frame_cls  <= NONE;
      r_frame_code <= '0;
    end else begin
      r_sync1      <= i_row_n;
      r_sync2      <= r_sync1;
      r_frame_done <= 1'b0;
      if (w_slot_end) begin
        r_slot  <= '0;
        r_col   <= w_col_next;
        r_col_n <= ~(COLS'(1) << w_col_next);
        if (w_col_last) begin
          r_frame_done <= 1'b1;
          r_frame_cls  <= (w_acc_cnt == 2'd0) ? NONE :
                          (w_acc_cnt == 2'd1) ? SINGLE : MULTI;
          r_frame_code <= w_acc_code;
          r_acc_cnt    <= 2'd0;
          r_acc_code   <= '0;
        end else begin
          r_acc_cnt  <= w_acc_cnt;
          r_acc_code <= w_acc_code;
        end
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end
    end
  end

  assign o_col_n      = r_col_n;
  assign o_frame_done = r_frame_done;
  assign o_frame_cls  = r_frame_cls;
  assign o_frame_code = r_frame_code;

endmodule

// File: rtl/kbd_matrix_scan.sv
// Key matrix scanner top: frame-level debounce FSM and key event outputs.
// Ports:
//   clk, RST     : clock, synchronous active-high reset
//   i_row_n      : raw active-low row lines
//   o_col_n      : column drive, exactly one bit low
//   o_key_code   : last accepted key index (row*COLS + col)
//   o_key_valid  : one-cycle pulse on an accepted press
//   o_key_held   : high from accepted press to accepted release
//   o_key_multi  : last completed frame saw more than one key down
module kbd_matrix_scan
  import kbd_pkg::*;
#(
  parameter int unsigned COLS       = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [ROWS-1:0]               i_row_n,
  output logic [COLS-1:0]               o_col_n,
  output logic [code_w(ROWS*COLS)-1:0]  o_key_code,
  output logic                          o_key_valid,
  output logic                          o_key_held,
  output logic                          o_key_multi
);

  localparam int unsigned CODE_W = code_w(ROWS * COLS);
  localparam int unsigned CNT_W  = code_w(DEB_FRAMES + 1);

  logic              w_frame_done;
  frame_cls_t        w_frame_cls;
  logic [CODE_W-1:0] w_frame_code;

  kbd_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_rcnt;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_key_held;
  logic              r_key_multi;

  kbd_col_scan #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clk          (clk),
    .RST          (RST),
    .i_row_n      (i_row_n),
    .o_col_n      (o_col_n),
    .o_frame_done (w_frame_done),
    .o_frame_cls  (w_frame_cls),
    .o_frame_code (w_frame_code)
  );

  // Debounce FSM; advances only on frame_done so counts are in whole frames.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_key_multi <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_done) begin
        r_key_multi <= (w_frame_cls == MULTI);
        case (r_state)
          IDLE: begin
            if (w_frame_cls == SINGLE) begin
              r_cand <= w_frame_code;
              r_cnt  <= CNT_W'(1);
              if (DEB_FRAMES == 1) begin
                r_state     <= PRESSED;
                r_key_code  <= w_frame_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_state <= CAND;
              end
            end
          end
          CAND: begin
            if (w_frame_cls == SINGLE) begin
              if (w_frame_code == r_cand) begin
                if (r_cnt + CNT_W'(1) == CNT_W'(DEB_FRAMES)) begin
                  r_state     <= PRESSED;
                  r_key_code  <= r_cand;
                  r_key_valid <= 1'b1;
                  r_key_held  <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end else begin
                r_cand <= w_frame_code;
                r_cnt  <= CNT_W'(1);
              end
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
          PRESSED: begin
            if (w_frame_cls == NONE) begin
              if (DEB_FRAMES == 1) begin
                r_state    <= IDLE;
                r_key_held <= 1'b0;
              end else begin
                r_state <= REL;
                r_rcnt  <= CNT_W'(1);
              end
            end
          end
          REL: begin
            if (w_frame_cls == NONE) begin
              if (r_rcnt + CNT_W'(1) == CNT_W'(DEB_FRAMES)) begin
                r_state    <= IDLE;
                r_rcnt     <= '0;
                r_key_held <= 1'b0;
              end else begin
                r_rcnt <= r_rcnt + CNT_W'(1);
              end
            end else begin
              r_state <= PRESSED;
              r_rcnt  <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;
  assign o_key_multi = r_key_multi;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Self-checking bench for kbd_matrix_scan with a keypad model and a
// scoreboard of expected key_valid events (code and arrival cycle).
module tb_kbd_matrix_scan;

  localparam int COLS    = 4;
  localparam int ROWS    = 4;
  localparam int FRAME   = 16;
  localparam int LATENCY = 3 * FRAME + 1;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_multi;

  logic [15:0] keys = '0;
  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int code;
    int cyc;
  } exp_t;
  exp_t sb[$];

  kbd_matrix_scan #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .SCAN_DIV   (4),
    .DEB_FRAMES (3)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .i_row_n     (row_n),
    .o_col_n     (col_n),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_held  (key_held),
    .o_key_multi (key_multi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a pressed key shorts its row to the active (low) column.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[r*COLS + c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int kc(input int r, input int c);
    return r * COLS + c;
  endfunction

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] v;
    v = '0;
    v[r*COLS + c] = 1'b1;
    return v;
  endfunction

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frames(input int n);
    run_cycles(n * FRAME);
  endtask

  // Called on the frame-aligned negedge where a press is applied.
  task automatic expect_press(input int r, input int c);
    exp_t e;
    e.code = kc(r, c);
    e.cyc  = cyc + LATENCY;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every key_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1 && !RST) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", int'(key_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_code", int'(key_code), e.code);
        chk("valid_cycle", cyc, e.cyc);
        chk("held_on_valid", int'(key_held), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    run_cycles(3);
    RST = 1'b0;

    // 1: column walk after reset release and reset output values
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_multi", int'(key_multi), 0);
    for (int n = 0; n <= 16; n++) begin
      int e;
      e = (~(1 << ((n / 4) % 4))) & 'hF;
      chk("col_walk", int'(col_n), e);
      if (n < 16) @(negedge clk);
    end

    // 2: steady press of (1,2), then release
    keys = kbit(1, 2);
    expect_press(1, 2);
    run_frames(3);
    chk("held_before_accept", int'(key_held), 0);
    run_cycles(1);
    chk("held_after_accept", int'(key_held), 1);
    run_cycles(FRAME - 1);
    keys = '0;
    run_frames(3);
    chk("held_before_release", int'(key_held), 1);
    run_cycles(1);
    chk("held_after_release", int'(key_held), 0);
    chk("code_kept", int'(key_code), kc(1, 2));
    run_cycles(FRAME - 1);

    // 3: bounce every frame, then stable
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? kbit(1, 2) : 16'h0;
      run_frames(1);
    end
    chk("bounce_no_hold", int'(key_held), 0);
    keys = kbit(1, 2);
    expect_press(1, 2);
    run_frames(3);
    run_cycles(1);
    chk("bounce_then_held", int'(key_held), 1);
    run_cycles(FRAME - 1);
    keys = '0;
    run_frames(4);
    chk("bounce_released", int'(key_held), 0);

    // 4: two keys from idle, then a second key while pressed
    keys = kbit(0, 0) | kbit(1, 1);
    run_frames(3);
    chk("multi_idle", int'(key_multi), 1);
    chk("multi_idle_held", int'(key_held), 0);
    keys = '0;
    run_frames(2);
    chk("multi_cleared", int'(key_multi), 0);
    keys = kbit(1, 2);
    expect_press(1, 2);
    run_frames(4);
    keys = kbit(1, 2) | kbit(2, 1);
    run_frames(2);
    chk("multi_pressed", int'(key_multi), 1);
    chk("multi_pressed_held", int'(key_held), 1);
    chk("multi_pressed_code", int'(key_code), kc(1, 2));

    // 5: slide to (0,3) with no gap, release, press (0,3)
    keys = kbit(0, 3);
    run_frames(3);
    chk("slide_multi", int'(key_multi), 0);
    chk("slide_held", int'(key_held), 1);
    chk("slide_code", int'(key_code), kc(1, 2));
    keys = '0;
    run_frames(4);
    chk("slide_released", int'(key_held), 0);
    keys = kbit(0, 3);
    expect_press(0, 3);
    run_frames(4);
    chk("second_key_held", int'(key_held), 1);
    chk("second_key_code", int'(key_code), kc(0, 3));

    // 6: reset while pressed with the key still down
    keys = '0;
    run_frames(4);
    keys = kbit(1, 2);
    expect_press(1, 2);
    run_frames(4);
    chk("pre_rst_held", int'(key_held), 1);
    run_cycles(5);
    RST = 1'b1;
    @(negedge clk);
    chk("mid_rst_col", int'(col_n), 14);
    chk("mid_rst_code", int'(key_code), 0);
    chk("mid_rst_held", int'(key_held), 0);
    chk("mid_rst_multi", int'(key_multi), 0);
    chk("mid_rst_valid", int'(key_valid), 0);
    RST = 1'b0;
    expect_press(1, 2);
    run_frames(3);
    chk("post_rst_wait", int'(key_held), 0);
    run_frames(1);
    chk("post_rst_held", int'(key_held), 1);
    chk("post_rst_code", int'(key_code), kc(1, 2));

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
